// File: rtl/aes_round_sched.sv
// AES round scheduler: accepts a plaintext block, performs the initial
// AddRoundKey, then steps an external round datapath through NR rounds,
// waiting ROUND_LAT cycles per round for its registered result, and
// presents the ciphertext on a valid/ready output.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     plaintext handshake, in_data plaintext block
//   rk_idx / rk           round-key index to the key store, key returned same cycle
//   rnd_state/rnd_key     operands driven into the round datapath
//   rnd_final             selects the final-round datapath (no MixColumns)
//   rnd_result            registered result of the round datapath
//   out_valid/out_ready   ciphertext handshake, out_data ciphertext block
//   busy                  high whenever a block is in flight
module aes_round_sched #(
    parameter int unsigned ROUND_LAT = 2,
    parameter int unsigned NR        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] rnd_state,
    output logic [127:0] rnd_key,
    output logic         rnd_final,
    input  logic [127:0] rnd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] NR_C     = CNT_W'(NR);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ROUND_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   data_q, data_d;
    logic [BLK_W-1:0]   st_q, st_d;
    logic [BLK_W-1:0]   key_hold_q;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic               in_ready_d;
    logic               busy_d;
    logic               out_valid_d;
    logic               rnd_final_d;
    logic [CNT_W-1:0]   rk_idx_d;
    logic [BLK_W-1:0]   rnd_state_d;
    logic [BLK_W-1:0]   out_data_d;

    // State, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            st_q       <= '0;
            key_hold_q <= '0;
            round_q    <= '0;
            wait_q     <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            rnd_final  <= 1'b0;
            rk_idx     <= '0;
            rnd_state  <= '0;
            out_data   <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            st_q       <= st_d;
            round_q    <= round_d;
            wait_q     <= wait_d;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            out_valid  <= out_valid_d;
            rnd_final  <= rnd_final_d;
            rk_idx     <= rk_idx_d;
            rnd_state  <= rnd_state_d;
            out_data   <= out_data_d;
            if (state_q == RUN) begin
                key_hold_q <= rk;
            end
        end
    end

    // Next-state logic and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        st_d       = st_q;
        round_d    = round_q;
        wait_d     = wait_q;
        out_data_d = out_data;

        unique case (state_q)
            IDLE: begin
                // in_ready is high exactly in IDLE, so in_valid alone accepts
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // rk_idx is 0 here, so rk is the whitening key
                st_d    = data_q ^ rk;
                round_d = CNT_W'(1);
                wait_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (wait_q == LAT_LAST) begin
                    st_d   = rnd_result;
                    wait_d = '0;
                    if (round_q == NR_C) begin
                        out_data_d = rnd_result;
                        state_d    = DONE;
                    end else begin
                        round_d = round_q + CNT_W'(1);
                    end
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        rk_idx_d    = (state_d == RUN) ? round_d : '0;
        rnd_final_d = (state_d == RUN) && (round_d == NR_C);
        // Round operand follows state_reg only while running; holds otherwise
        rnd_state_d = (state_d == RUN) ? st_d : rnd_state;
    end

    // Key store answers rk_idx in the same cycle, so the key is passed through
    // while running and the last one used is held elsewhere.
    assign rnd_key = (state_q == RUN) ? rk : key_hold_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: two instances (AES-128 latency 2, AES-256
// latency 3) driven by a behavioural AES round model and key store.
module tb_aes_round_sched;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned NR_A  = 10;
    localparam int unsigned LAT_B = 3;
    localparam int unsigned NR_B  = 14;

    localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_a, in_ready_a, rnd_final_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] in_data_a, rk_a, rnd_state_a, rnd_key_a, rnd_result_a, out_data_a;
    logic [3:0]   rk_idx_a;
    logic         in_valid_b, in_ready_b, rnd_final_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] in_data_b, rk_b, rnd_state_b, rnd_key_b, rnd_result_b, out_data_b;
    logic [3:0]   rk_idx_b;

    aes_round_sched #(.ROUND_LAT(LAT_A), .NR(NR_A)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .rk_idx(rk_idx_a), .rk(rk_a),
        .rnd_state(rnd_state_a), .rnd_key(rnd_key_a), .rnd_final(rnd_final_a),
        .rnd_result(rnd_result_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .busy(busy_a)
    );

    aes_round_sched #(.ROUND_LAT(LAT_B), .NR(NR_B)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .rk_idx(rk_idx_b), .rk(rk_b),
        .rnd_state(rnd_state_b), .rnd_key(rnd_key_b), .rnd_final(rnd_final_b),
        .rnd_result(rnd_result_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural AES ----------------
    logic [7:0]   sbox [256];
    logic [127:0] ks_a [16];
    logic [127:0] ks_b [16];

    assign rk_a = ks_a[rk_idx_a];
    assign rk_b = ks_b[rk_idx_b];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit sel);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (sel) ks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else     ks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // One AES round on a column-major byte state (byte 0 in the top bits)
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                b[rw+4*c] = a[rw+4*((c+rw)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(c0, 8'd2) ^ gmul(c1, 8'd3) ^ c2 ^ c3;
                b[4*c+1] = c0 ^ gmul(c1, 8'd2) ^ gmul(c2, 8'd3) ^ c3;
                b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'd2) ^ gmul(c3, 8'd3);
                b[4*c+3] = gmul(c0, 8'd3) ^ c1 ^ c2 ^ gmul(c3, 8'd2);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input bit sel);
        logic [127:0] s;
        int nr;
        nr = sel ? int'(NR_B) : int'(NR_A);
        s = pt ^ (sel ? ks_b[0] : ks_a[0]);
        for (int r = 1; r <= nr; r++)
            s = aes_round(s, sel ? ks_b[r] : ks_a[r], r == nr);
        return s;
    endfunction

    // Round datapath model: result is correct only on the cycle the operands
    // have been presented for the full latency; garbage on every other cycle.
    int         run_a = 0;
    int         run_b = 0;
    logic [3:0] prev_a = 4'd0;
    logic [3:0] prev_b = 4'd0;

    always @(posedge clk) begin
        #1;
        if (rk_idx_a != 4'd0 && rk_idx_a == prev_a) run_a = run_a + 1;
        else run_a = (rk_idx_a != 4'd0) ? 1 : 0;
        prev_a = rk_idx_a;
        if (run_a == int'(LAT_A)) rnd_result_a = aes_round(rnd_state_a, rnd_key_a, rnd_final_a);
        else rnd_result_a = {$urandom, $urandom, $urandom, $urandom};
    end

    always @(posedge clk) begin
        #1;
        if (rk_idx_b != 4'd0 && rk_idx_b == prev_b) run_b = run_b + 1;
        else run_b = (rk_idx_b != 4'd0) ? 1 : 0;
        prev_b = rk_idx_b;
        if (run_b == int'(LAT_B)) rnd_result_b = aes_round(rnd_state_b, rnd_key_b, rnd_final_b);
        else rnd_result_b = {$urandom, $urandom, $urandom, $urandom};
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        int           stall;
        bit           noise;
    } vec_t;

    vec_t tab [6];

    // One block through instance A with an optional consumer stall and
    // optional in_valid traffic while busy.
    task automatic run_a_blk(input vec_t v);
        int           lat;
        logic [127:0] held;
        chk_i("in_ready_before_accept", int'(in_ready_a), 1);
        in_valid_a  = 1'b1;
        in_data_a   = v.pt;
        out_ready_a = 1'b0;
        tick();
        in_valid_a = v.noise;
        in_data_a  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid_a && lat < 200) begin
            tick();
            lat++;
        end
        in_valid_a = 1'b0;
        chk_i("latency", lat, int'(1 + NR_A*LAT_A));
        chk("ciphertext", out_data_a, v.ct);
        held = out_data_a;
        for (int i = 0; i < v.stall; i++) begin
            tick();
            chk("stall_out_data", out_data_a, held);
            chk_i("stall_out_valid", int'(out_valid_a), 1);
            chk_i("stall_in_ready", int'(in_ready_a), 0);
            chk_i("stall_busy", int'(busy_a), 1);
        end
        out_ready_a = 1'b1;
        chk_i("done_in_ready_with_out_ready", int'(in_ready_a), 0);
        tick();
        out_ready_a = 1'b0;
        chk_i("idle_in_ready", int'(in_ready_a), 1);
        chk_i("idle_out_valid", int'(out_valid_a), 0);
        chk_i("idle_busy", int'(busy_a), 0);
        chk_i("idle_rk_idx", int'(rk_idx_a), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] bb_pt [3];
        logic [127:0] bb_ct [3];
        int           acc_t [4];
        int           nacc;
        int           nout;
        int           n;
        int           exp_idx [43];

        rst = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0; rnd_result_a = '0;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0; rnd_result_b = '0;
        for (int i = 0; i < 16; i++) begin
            ks_a[i] = '0;
            ks_b[i] = '0;
        end
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, int'(NR_A), 1'b0);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               8, int'(NR_B), 1'b1);

        tab[0].pt = FIPS_PT; tab[0].ct = FIPS_CT128; tab[0].stall = 0; tab[0].noise = 1'b0;
        tab[1].pt = FIPS_PT; tab[1].ct = FIPS_CT128; tab[1].stall = 5; tab[1].noise = 1'b0;
        for (int i = 2; i < 6; i++) begin
            tab[i].pt    = {$urandom, $urandom, $urandom, $urandom};
            tab[i].ct    = aes_enc(tab[i].pt, 1'b0);
            tab[i].stall = int'($urandom_range(0, 3));
            tab[i].noise = (i % 2) == 0;
        end

        #1 rst = 1'b1;
        #2;
        chk_i("rst_in_ready", int'(in_ready_a), 1);
        chk_i("rst_busy", int'(busy_a), 0);
        chk_i("rst_out_valid", int'(out_valid_a), 0);
        chk_i("rst_rnd_final", int'(rnd_final_a), 0);
        chk_i("rst_rk_idx", int'(rk_idx_a), 0);
        chk("rst_out_data", out_data_a, '0);
        chk("rst_rnd_state", rnd_state_a, '0);
        chk("rst_rnd_key", rnd_key_a, '0);
        chk_i("rst_in_ready_b", int'(in_ready_b), 1);
        tick();
        rst = 1'b0;

        // Table of blocks, applied back to back from reset release
        for (int i = 0; i < 6; i++) run_a_blk(tab[i]);

        // Streaming: in_valid and out_ready held high
        for (int i = 0; i < 3; i++) begin
            bb_pt[i] = {$urandom, $urandom, $urandom, $urandom};
            bb_ct[i] = aes_enc(bb_pt[i], 1'b0);
        end
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        in_data_a   = bb_pt[0];
        nacc = 0;
        nout = 0;
        for (int t = 0; t < 300 && nout < 3; t++) begin
            if (in_ready_a && in_valid_a) begin
                acc_t[nacc] = t;
                nacc++;
            end
            tick();
            if (nacc >= 3) in_valid_a = 1'b0;
            else in_data_a = bb_pt[nacc];
            if (out_valid_a) begin
                chk("stream_ct", out_data_a, bb_ct[nout]);
                nout++;
            end
        end
        chk_i("stream_outputs", nout, 3);
        chk_i("stream_accepts", nacc, 3);
        chk_i("stream_spacing_1", acc_t[1] - acc_t[0], int'(3 + NR_A*LAT_A));
        chk_i("stream_spacing_2", acc_t[2] - acc_t[1], int'(3 + NR_A*LAT_A));
        in_valid_a = 1'b0;
        tick();
        tick();
        out_ready_a = 1'b0;

        // Reset in the middle of round 6, then a fresh block
        in_valid_a = 1'b1;
        in_data_a  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid_a = 1'b0;
        n = 0;
        while (rk_idx_a != 4'd6 && n < 100) begin
            tick();
            n++;
        end
        chk_i("reach_round6", int'(rk_idx_a), 6);
        rst = 1'b1;
        #1;
        chk_i("midrst_in_ready", int'(in_ready_a), 1);
        chk_i("midrst_out_valid", int'(out_valid_a), 0);
        chk_i("midrst_rk_idx", int'(rk_idx_a), 0);
        chk_i("midrst_busy", int'(busy_a), 0);
        chk("midrst_rnd_state", rnd_state_a, '0);
        chk("midrst_out_data", out_data_a, '0);
        tick();
        rst = 1'b0;
        run_a_blk(tab[0]);
        run_a_blk(tab[3]);

        // AES-256, latency 3: key-index sequence, final flag, latency, result
        exp_idx[0] = 0;
        for (int r = 1; r <= int'(NR_B); r++)
            for (int j = 0; j < int'(LAT_B); j++)
                exp_idx[1 + int'(LAT_B)*(r-1) + j] = r;
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        in_data_b   = FIPS_PT;
        chk_i("b_in_ready", int'(in_ready_b), 1);
        tick();
        in_valid_b = 1'b0;
        for (int i = 0; i < 43; i++) begin
            chk_i("b_rk_idx_seq", int'(rk_idx_b), exp_idx[i]);
            chk_i("b_rnd_final_seq", int'(rnd_final_b), (exp_idx[i] == int'(NR_B)) ? 1 : 0);
            chk_i("b_no_early_valid", int'(out_valid_b), 0);
            tick();
        end
        chk_i("b_out_valid_at_43", int'(out_valid_b), 1);
        chk("b_ciphertext", out_data_b, FIPS_CT256);
        tick();
        chk_i("b_idle_in_ready", int'(in_ready_b), 1);
        chk_i("b_idle_out_valid", int'(out_valid_b), 0);
        out_ready_b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
